// File: rtl/keypad_pkg.sv
// keypad_matrix_emu shared definitions
// key codes, row/column strobes, FSM encoding, key decode table
package keypad_pkg;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  localparam logic [2:0] COL1 = 3'b100;
  localparam logic [2:0] COL2 = 3'b010;
  localparam logic [2:0] COL3 = 3'b001;

  localparam logic [3:0] ROW1 = 4'b1000;
  localparam logic [3:0] ROW2 = 4'b0100;
  localparam logic [3:0] ROW3 = 4'b0010;
  localparam logic [3:0] ROW4 = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // {col[2:0], row[3:0]}; all-zero for codes outside 0..11
  function automatic logic [6:0] key_to_colrow(
    input logic [3:0] code
  );
    logic [6:0] v;
    v = '0;
    unique case (code)
      4'd1:     v = {COL1, ROW1};
      4'd4:     v = {COL1, ROW2};
      4'd7:     v = {COL1, ROW3};
      KEY_STAR: v = {COL1, ROW4};
      4'd2:     v = {COL2, ROW1};
      4'd5:     v = {COL2, ROW2};
      4'd8:     v = {COL2, ROW3};
      4'd0:     v = {COL2, ROW4};
      4'd3:     v = {COL3, ROW1};
      4'd6:     v = {COL3, ROW2};
      4'd9:     v = {COL3, ROW3};
      KEY_HASH: v = {COL3, ROW4};
      default:  v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/keypad_matrix_emu_if.sv
// keypad_matrix_emu bus
// key request handshake, scan strobes/returns, status pulses
interface keypad_matrix_emu_if;

  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic [2:0] scan_key;
  logic [3:0] touch_key;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output key_code,
    output key_valid,
    output scan_key,
    input  key_ready,
    input  touch_key,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  scan_key,
    output key_ready,
    output touch_key,
    output busy,
    output done,
    output err
  );

endinterface

// File: rtl/keypad_scan_sync.sv
// keypad_scan_sync
// column strobe synchroniser and scan-round start detector
module keypad_scan_sync
  import keypad_pkg::*;
(
  input  logic       fin,
  input  logic       rst,
  input  logic [2:0] i_scan,
  output logic [2:0] o_col,
  output logic       o_round_start
);

  logic [2:0] r_s1;
  logic [2:0] r_s2;
  logic [2:0] r_prev;

  // two capture flops plus one stage of history for edge detect
  always_ff @(posedge fin or negedge rst) begin
    if (!rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
    end else begin
      r_s1   <= i_scan;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign o_col         = r_s2;
  assign o_round_start = (r_s2 == COL1) && (r_prev != COL1);

endmodule

// File: rtl/keypad_matrix_emu.sv
// keypad_matrix_emu
// key-switch side of a 3x4 scanned keypad
module keypad_matrix_emu
  import keypad_pkg::*;
#(
  parameter int HOLD_SCANS  = 4,
  parameter int GAP_SCANS   = 2,
  parameter int TIMEOUT_CYC = 262144
) (
  input  logic                fin,
  input  logic                rst,
  keypad_matrix_emu_if.slave  bus
);

  localparam int MAXR = (HOLD_SCANS > GAP_SCANS) ?
                        HOLD_SCANS : GAP_SCANS;
  localparam int CW   = $clog2(MAXR + 1);
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_PRESS = ST_PRESS;
  localparam logic [1:0] S_GAP   = ST_GAP;

  logic [1:0]    r_state;
  logic [2:0]    r_col;
  logic [3:0]    r_row;
  logic [CW-1:0] r_rounds;
  logic [TW-1:0] r_timer;
  logic          r_done;
  logic          r_err;

  logic [2:0]    w_unused_col;
  logic          w_rs;
  logic [6:0]    w_colrow;
  logic          w_legal;
  logic          w_pressed;
  logic [CW-1:0] w_rounds_nx;
  logic [CW-1:0] w_target;
  logic [TW-1:0] w_tmr_nx;

  keypad_scan_sync u_sync (
    .fin           (fin),
    .rst           (rst),
    .i_scan        (bus.scan_key),
    .o_col         (w_unused_col),
    .o_round_start (w_rs)
  );

  assign w_colrow  = key_to_colrow(bus.key_code);
  assign w_legal   = (bus.key_code <= KEY_HASH);
  assign w_pressed = (r_state == S_PRESS);

  assign w_rounds_nx = (r_rounds == CW'(MAXR)) ?
                       r_rounds : r_rounds + 1'b1;
  assign w_target    = (r_state == S_PRESS) ?
                       CW'(HOLD_SCANS) : CW'(GAP_SCANS);
  assign w_tmr_nx    = (r_timer == '1) ?
                       r_timer : r_timer + 1'b1;

  // passive switch: row returns only on an exact column match
  assign bus.touch_key = (w_pressed && bus.scan_key == r_col) ?
                         r_row : 4'b0000;

  assign bus.key_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.err       = r_err;

  // press/gap sequencer with round counting and scan timeout
  always_ff @(posedge fin or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_col    <= '0;
      r_row    <= '0;
      r_rounds <= '0;
      r_timer  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.key_valid) begin
            if (w_legal) begin
              r_col    <= w_colrow[6:4];
              r_row    <= w_colrow[3:0];
              r_rounds <= '0;
              r_timer  <= '0;
              r_state  <= S_PRESS;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_PRESS, S_GAP: begin
          if (w_rs) begin
            r_timer <= '0;
            if (w_rounds_nx == w_target) begin
              r_rounds <= '0;
              if (r_state == S_PRESS) begin
                r_state <= S_GAP;
              end else begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end
            end else begin
              r_rounds <= w_rounds_nx;
            end
          end else if (w_tmr_nx == TW'(TIMEOUT_CYC)) begin
            r_timer  <= '0;
            r_rounds <= '0;
            r_err    <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_timer <= w_tmr_nx;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
